// File: rtl/spi_mem_master.sv
// spi_mem_master
//   SPI (mode 0) slave front end that turns SPI frames into single 32-bit
//   memory transactions on a simple request/rvalid bus.
//
//   Frames (MSB first on the wire):
//     0x02 A3 A2 A1 A0 D3 D2 D1 D0  write word D to address A
//     0x03 A3 A2 A1 A0 xx R3..R0    read word; 8 dummy bits (miso=0), then data
//     0x05 S                        status {4'b0, OVERRUN, LATE, TIMEOUT, ERR},
//                                   the flags clear once the byte is shifted out
//     other                         ignored, miso held 0
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   spi_cs_n/sck/mosi SPI inputs, asynchronous to clk
//   spi_miso          SPI output, changes on sck falling edges
//   mem_req_o         request, held until mem_rvalid_i or timeout
//   mem_addr_o        request address
//   mem_we_o          1 = write, 0 = read
//   mem_be_o          4'hF while a request is active, else 0
//   mem_wdata_o       write data
//   mem_rvalid_i      single-cycle completion strobe
//   mem_err_i         error flag, valid with mem_rvalid_i
//   mem_rdata_i       read data, valid with mem_rvalid_i
//   busy_o            a memory transaction is outstanding
module spi_mem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        WDATA  = 3'd3,
        DUMMY  = 3'd4,
        RESP   = 3'd5,
        IGNORE = 3'd6
    } state_t;

    // Synchronizers plus one delay stage for edge detection
    logic [1:0] cs_sync_r;
    logic [1:0] sck_sync_r;
    logic [1:0] mosi_sync_r;
    logic       cs_prev_r;
    logic       sck_prev_r;

    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       sck_rise_s;
    logic       sck_fall_s;
    logic       mosi_s;

    state_t           state_r;
    logic [5:0]       bit_cnt_r;
    logic [31:0]      shift_r;
    logic [31:0]      shift_next_s;
    logic [31:0]      addr_r;
    logic [31:0]      rdata_r;
    logic [31:0]      tx_r;
    logic             is_write_r;
    logic             is_status_r;
    logic             flag_err_r;
    logic             flag_tmo_r;
    logic             flag_late_r;
    logic             flag_ovr_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [7:0]       status_s;
    logic             status_clr_s;
    logic [5:0]       resp_last_s;

    assign cs_fall_s    = cs_prev_r & ~cs_sync_r[1];
    assign cs_rise_s    = ~cs_prev_r & cs_sync_r[1];
    assign sck_rise_s   = ~sck_prev_r & sck_sync_r[1];
    assign sck_fall_s   = sck_prev_r & ~sck_sync_r[1];
    assign mosi_s       = mosi_sync_r[1];
    assign shift_next_s = {shift_r[30:0], mosi_s};
    assign status_s     = {4'b0000, flag_ovr_r, flag_late_r, flag_tmo_r, flag_err_r};
    assign resp_last_s  = is_status_r ? 6'd7 : 6'd31;

    // The falling edge that drives bit 0 of the status byte clears the flags
    assign status_clr_s = (state_r == RESP) && is_status_r && sck_fall_s &&
                          (bit_cnt_r == 6'd7) && !cs_rise_s;

    // Bring the SPI pins into the clk domain; cs_n idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_r   <= 2'b11;
            sck_sync_r  <= 2'b00;
            mosi_sync_r <= 2'b00;
            cs_prev_r   <= 1'b1;
            sck_prev_r  <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], spi_cs_n};
            sck_sync_r  <= {sck_sync_r[0], spi_sck};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
            cs_prev_r   <= cs_sync_r[1];
            sck_prev_r  <= sck_sync_r[1];
        end
    end

    // Frame FSM, memory request handshake and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 6'd0;
            shift_r     <= 32'h0000_0000;
            addr_r      <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            tx_r        <= 32'h0000_0000;
            is_write_r  <= 1'b0;
            is_status_r <= 1'b0;
            flag_err_r  <= 1'b0;
            flag_tmo_r  <= 1'b0;
            flag_late_r <= 1'b0;
            flag_ovr_r  <= 1'b0;
            tmo_cnt_r   <= '0;
            spi_miso    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= 32'h0000_0000;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= 32'h0000_0000;
            busy_o      <= 1'b0;
        end else begin
            // Clear first so a flag raised in the same cycle is not lost
            if (status_clr_s) begin
                flag_err_r  <= 1'b0;
                flag_tmo_r  <= 1'b0;
                flag_late_r <= 1'b0;
                flag_ovr_r  <= 1'b0;
            end

            // Outstanding request: complete on rvalid or give up on timeout.
            // This runs independently of the frame so aborts cannot orphan it.
            if (mem_req_o) begin
                if (mem_rvalid_i) begin
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                    mem_be_o  <= 4'h0;
                    busy_o    <= 1'b0;
                    if (!mem_we_o) begin
                        rdata_r <= mem_rdata_i;
                    end
                    if (mem_err_i) begin
                        flag_err_r <= 1'b1;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    mem_req_o  <= 1'b0;
                    mem_we_o   <= 1'b0;
                    mem_be_o   <= 4'h0;
                    busy_o     <= 1'b0;
                    flag_tmo_r <= 1'b1;
                    rdata_r    <= 32'hFFFF_FFFF;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end
            end

            if (cs_rise_s) begin
                // Deselect always ends the frame, whatever phase it was in
                state_r  <= IDLE;
                spi_miso <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (cs_fall_s) begin
                            bit_cnt_r   <= 6'd0;
                            is_status_r <= 1'b0;
                            if (busy_o) begin
                                state_r    <= IGNORE;
                                flag_ovr_r <= 1'b1;
                            end else begin
                                state_r <= CMD;
                            end
                        end
                    end

                    CMD: begin
                        if (sck_rise_s) begin
                            shift_r <= shift_next_s;
                            if (bit_cnt_r == 6'd7) begin
                                bit_cnt_r <= 6'd0;
                                case (shift_next_s[7:0])
                                    8'h02: begin
                                        state_r    <= ADDR;
                                        is_write_r <= 1'b1;
                                    end
                                    8'h03: begin
                                        state_r    <= ADDR;
                                        is_write_r <= 1'b0;
                                    end
                                    8'h05: begin
                                        state_r     <= RESP;
                                        is_status_r <= 1'b1;
                                        tx_r        <= {status_s, 24'h00_0000};
                                    end
                                    default: begin
                                        state_r <= IGNORE;
                                    end
                                endcase
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                            end
                        end
                    end

                    ADDR: begin
                        if (sck_rise_s) begin
                            shift_r <= shift_next_s;
                            if (bit_cnt_r == 6'd31) begin
                                bit_cnt_r <= 6'd0;
                                addr_r    <= shift_next_s;
                                if (is_write_r) begin
                                    state_r <= WDATA;
                                end else begin
                                    state_r <= DUMMY;
                                    if (!mem_req_o) begin
                                        mem_req_o  <= 1'b1;
                                        busy_o     <= 1'b1;
                                        mem_we_o   <= 1'b0;
                                        mem_be_o   <= 4'hF;
                                        mem_addr_o <= shift_next_s;
                                        tmo_cnt_r  <= '0;
                                    end
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                            end
                        end
                    end

                    WDATA: begin
                        if (sck_rise_s) begin
                            shift_r <= shift_next_s;
                            if (bit_cnt_r == 6'd31) begin
                                bit_cnt_r <= 6'd0;
                                state_r   <= IGNORE;
                                if (!mem_req_o) begin
                                    mem_req_o   <= 1'b1;
                                    busy_o      <= 1'b1;
                                    mem_we_o    <= 1'b1;
                                    mem_be_o    <= 4'hF;
                                    mem_addr_o  <= addr_r;
                                    mem_wdata_o <= shift_next_s;
                                    tmo_cnt_r   <= '0;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                            end
                        end
                    end

                    DUMMY: begin
                        if (sck_rise_s) begin
                            if (bit_cnt_r == 6'd7) begin
                                bit_cnt_r <= 6'd0;
                                state_r   <= RESP;
                                // Read still pending: answer with all ones
                                if (busy_o) begin
                                    tx_r        <= 32'hFFFF_FFFF;
                                    flag_late_r <= 1'b1;
                                end else begin
                                    tx_r <= rdata_r;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                            end
                        end
                    end

                    RESP: begin
                        if (sck_fall_s) begin
                            spi_miso <= tx_r[31];
                            tx_r     <= {tx_r[30:0], 1'b0};
                        end
                        if (sck_rise_s) begin
                            if (bit_cnt_r == resp_last_s) begin
                                bit_cnt_r <= 6'd0;
                                state_r   <= IGNORE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 6'd1;
                            end
                        end
                    end

                    IGNORE: begin
                        if (sck_fall_s) begin
                            spi_miso <= 1'b0;
                        end
                    end

                    default: begin
                        state_r  <= IDLE;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master
//   Directed bench for spi_mem_master: bit-banged SPI mode-0 frames with a
//   per-test memory responder, hand-computed expected values.
module tb_spi_mem_master;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic        mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int req_count  = 0;
    int req_cycles = 0;
    logic req_d = 1'b0;

    spi_mem_master #(.TIMEOUT_CYCLES(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_err_i    (mem_err_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    // 10 time-unit system clock
    always #5 clk = ~clk;

    // Count request launches and the number of cycles a request is held
    always @(negedge clk) begin
        if (mem_req_o) req_cycles <= req_cycles + 1;
        if (mem_req_o && !req_d) req_count <= req_count + 1;
        req_d <= mem_req_o;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        spi_cs_n = 1'b0;
        clk_wait(6);
    endtask

    task automatic spi_end();
        clk_wait(HALF);
        spi_cs_n = 1'b1;
        clk_wait(8);
    endtask

    // Shift nbits of tx out MSB first; miso is sampled just before each rising edge
    task automatic spi_xfer(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = 32'h0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            clk_wait(HALF);
            rx = {rx[30:0], spi_miso};
            spi_sck = 1'b1;
            clk_wait(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic read_status(input logic [7:0] exp, input string tag);
        logic [31:0] rx;
        spi_start();
        spi_xfer(32'h05, 8, rx);
        spi_xfer(32'h00, 8, rx);
        spi_end();
        total++;
        if (rx[7:0] !== exp) begin
            bad++;
            $display("FAIL %s: status got %h want %h", tag, rx[7:0], exp);
        end
    endtask

    // Wait for a request, check it, complete it after 'delay' cycles
    task automatic respond(input int delay, input logic [31:0] rd, input logic err,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_wdata, input string tag);
        int w = 0;
        while (mem_req_o !== 1'b1 && w < 3000) begin
            clk_wait(1);
            w++;
        end
        total++;
        if (mem_req_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_seen: got %b want 1", tag, mem_req_o);
        end else begin
            total++;
            if ({mem_addr_o, mem_we_o, mem_be_o} !== {exp_addr, exp_we, 4'hF}) begin
                bad++;
                $display("FAIL %s_fields: got addr=%h we=%b be=%h want addr=%h we=%b be=f",
                         tag, mem_addr_o, mem_we_o, mem_be_o, exp_addr, exp_we);
            end
            if (exp_we) begin
                total++;
                if (mem_wdata_o !== exp_wdata) begin
                    bad++;
                    $display("FAIL %s_wdata: got %h want %h", tag, mem_wdata_o, exp_wdata);
                end
            end
            clk_wait(delay);
            total++;
            if (mem_req_o !== 1'b1) begin
                bad++;
                $display("FAIL %s_held: got %b want 1", tag, mem_req_o);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd;
            mem_err_i    = err;
            clk_wait(1);
            mem_rvalid_i = 1'b0;
            mem_err_i    = 1'b0;
            total++;
            if ({mem_req_o, mem_be_o, busy_o} !== 6'b0) begin
                bad++;
                $display("FAIL %s_drop: got req=%b be=%h busy=%b want 0 0 0",
                         tag, mem_req_o, mem_be_o, busy_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i = 1'b0;
        mem_rdata_i = 32'h0;
        clk_wait(3);
        total++;
        if ({spi_miso, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o} !== 72'h0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b be=%h addr=%h wdata=%h busy=%b want all 0",
                     mem_req_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o);
        end
        rst = 1'b0;
        clk_wait(3);
    endtask

    task automatic test_write();
        logic [31:0] rx;
        int c0 = req_count;
        fork
            begin
                spi_start();
                spi_xfer(32'h02, 8, rx);
                spi_xfer(32'h0000_1004, 32, rx);
                spi_xfer(32'hCAFE_BABE, 32, rx);
                spi_end();
            end
            respond(3, 32'h0, 1'b0, 32'h0000_1004, 1'b1, 32'hCAFE_BABE, "write");
        join
        total++;
        if (req_count - c0 !== 1) begin
            bad++;
            $display("FAIL write_count: got %0d want 1", req_count - c0);
        end
    endtask

    task automatic test_read();
        logic [31:0] rx;
        fork
            begin
                spi_start();
                spi_xfer(32'h03, 8, rx);
                spi_xfer(32'h0000_1008, 32, rx);
                spi_xfer(32'h00, 8, rx);
                total++;
                if (rx[7:0] !== 8'h00) begin
                    bad++;
                    $display("FAIL read_dummy: got %h want 00", rx[7:0]);
                end
                spi_xfer(32'h0, 32, rx);
                total++;
                if (rx !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL read_data: got %h want 12345678", rx);
                end
                spi_end();
            end
            respond(2, 32'h1234_5678, 1'b0, 32'h0000_1008, 1'b0, 32'h0, "read");
        join
    endtask

    task automatic test_error();
        logic [31:0] rx;
        fork
            begin
                spi_start();
                spi_xfer(32'h03, 8, rx);
                spi_xfer(32'h0000_100C, 32, rx);
                spi_xfer(32'h00, 8, rx);
                spi_xfer(32'h0, 32, rx);
                spi_end();
            end
            respond(2, 32'hDEAD_BEEF, 1'b1, 32'h0000_100C, 1'b0, 32'h0, "err");
        join
        read_status(8'h01, "err_status");
    endtask

    task automatic test_timeout();
        logic [31:0] rx;
        int c0 = req_cycles;
        spi_start();
        spi_xfer(32'h03, 8, rx);
        spi_xfer(32'h0000_2000, 32, rx);
        clk_wait(300);
        total++;
        if (req_cycles - c0 !== 255) begin
            bad++;
            $display("FAIL tmo_cycles: got %0d want 255", req_cycles - c0);
        end
        total++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            bad++;
            $display("FAIL tmo_drop: got req=%b busy=%b want 0 0", mem_req_o, busy_o);
        end
        spi_xfer(32'h00, 8, rx);
        spi_xfer(32'h0, 32, rx);
        total++;
        if (rx !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL tmo_data: got %h want ffffffff", rx);
        end
        spi_end();
        read_status(8'h02, "tmo_status");
        read_status(8'h00, "tmo_status_cleared");
    endtask

    task automatic test_late();
        logic [31:0] rx;
        fork
            begin
                spi_start();
                spi_xfer(32'h03, 8, rx);
                spi_xfer(32'h0000_5000, 32, rx);
                spi_xfer(32'h00, 8, rx);
                spi_xfer(32'h0, 32, rx);
                total++;
                if (rx !== 32'hFFFF_FFFF) begin
                    bad++;
                    $display("FAIL late_data: got %h want ffffffff", rx);
                end
                spi_end();
            end
            respond(200, 32'h1111_1111, 1'b0, 32'h0000_5000, 1'b0, 32'h0, "late");
        join
        read_status(8'h04, "late_status");
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        int c0 = req_count;
        spi_start();
        spi_xfer(32'h02, 8, rx);
        spi_xfer(32'h0000_3000, 32, rx);
        spi_xfer(32'h000A_BCDE, 20, rx);
        spi_end();
        clk_wait(20);
        total++;
        if (req_count - c0 !== 0 || mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_write: got %0d requests want 0", req_count - c0);
        end
        fork
            begin
                spi_start();
                spi_xfer(32'h03, 8, rx);
                spi_xfer(32'h0000_4000, 32, rx);
                spi_xfer(32'h0, 3, rx);
                spi_end();
                total++;
                if (busy_o !== 1'b1) begin
                    bad++;
                    $display("FAIL abort_read_busy: got %b want 1", busy_o);
                end
            end
            respond(150, 32'h0BAD_F00D, 1'b0, 32'h0000_4000, 1'b0, 32'h0, "abort_rd");
        join
        read_status(8'h00, "abort_status");
    endtask

    task automatic test_overrun();
        logic [31:0] rx;
        logic [31:0] rx_or;
        int c0 = req_count;
        fork
            begin
                spi_start();
                spi_xfer(32'h02, 8, rx);
                spi_xfer(32'h0000_6000, 32, rx);
                spi_xfer(32'h1122_3344, 32, rx);
                spi_end();
                spi_start();
                spi_xfer(32'h02, 8, rx);
                rx_or = rx;
                spi_xfer(32'h0000_7000, 32, rx);
                rx_or = rx_or | rx;
                spi_xfer(32'h5566_7788, 32, rx);
                rx_or = rx_or | rx;
                spi_end();
            end
            respond(100, 32'h0, 1'b0, 32'h0000_6000, 1'b1, 32'h1122_3344, "ovr_first");
        join
        clk_wait(20);
        total++;
        if (req_count - c0 !== 1) begin
            bad++;
            $display("FAIL ovr_count: got %0d want 1", req_count - c0);
        end
        total++;
        if (rx_or !== 32'h0) begin
            bad++;
            $display("FAIL ovr_miso: got %h want 0", rx_or);
        end
        read_status(8'h08, "ovr_status");
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx;
        spi_start();
        spi_xfer(32'h03, 8, rx);
        spi_xfer(32'h0000_8000, 32, rx);
        clk_wait(5);
        total++;
        if (mem_req_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pending: got %b want 1", mem_req_o);
        end
        rst = 1'b1;
        clk_wait(1);
        total++;
        if ({spi_miso, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, busy_o} !== 72'h0) begin
            bad++;
            $display("FAIL rstmid_outputs: got req=%b be=%h addr=%h busy=%b want all 0",
                     mem_req_o, mem_be_o, mem_addr_o, busy_o);
        end
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        clk_wait(2);
        rst = 1'b0;
        clk_wait(5);
        total++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_after: got req=%b busy=%b want 0 0", mem_req_o, busy_o);
        end
        read_status(8'h00, "rstmid_status");
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_late();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
